// File: rtl/rs485_uart_rx_if.sv
// rtl/rs485_uart_rx_if.sv - receive-side status bundle from rs485_uart_rx to the packet logic
// Ports (signals):
//   rx_data    [DATA_W] last received word, holds until the next rx_valid
//   rx_valid            one-clk strobe marking new rx_data/frame_err/parity_err
//   frame_err           stop bit sampled low, meaningful only with rx_valid
//   parity_err          parity mismatch, meaningful only with rx_valid
//   rx_busy             receiver is somewhere other than IDLE
// Modports: master = receiver (drives), slave = consumer (reads).
interface rs485_uart_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              parity_err;
  logic              rx_busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, rx_busy
  );

  modport slave (
    input rx_data, rx_valid, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/rs485_uart_rx.sv
// rtl/rs485_uart_rx.sv - RS485 UART receive deserialiser driven by a 16x oversample tick
// Purpose: synchronise rxd, detect the start bit, 2-of-3 majority-sample each bit around
//   mid-cell, assemble an LSB-first word and strobe it out with frame/parity status.
// Optional feature: define RS485_RX_PARITY_EN for one even-parity bit after the data bits.
// Ports:
//   clk    in  system clock (posedge)
//   reset  in  asynchronous, active-low reset
//   bclk   in  oversample enable; state only advances on clk edges where bclk=1
//   rxd    in  asynchronous line input, idle high
//   rx     rs485_uart_rx_if.master: rx_data, rx_valid, frame_err, parity_err, rx_busy
module rs485_uart_rx #(
  parameter int DATA_W      = 8,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk,
  input  logic                 rxd,
  rs485_uart_rx_if.master      rx
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Sample points: two early samples are stored, the third is taken live at the decision tick.
  localparam logic [TW-1:0] T_LO   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVS/2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;
  logic [TW-1:0]          tick;
  logic [BW-1:0]          bitc;
  logic [DATA_W-1:0]      shift;
  logic [1:0]             samp;
  logic                   vote;
`ifdef RS485_RX_PARITY_EN
  logic                   par_bit;
`endif

  assign rxd_s = sync[SYNC_STAGES-1];
  assign vote  = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);

  // The synchroniser runs every clk so metastability settling does not depend on bclk rate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rxd};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tick          <= '0;
      bitc          <= '0;
      shift         <= '0;
      samp          <= '0;
`ifdef RS485_RX_PARITY_EN
      par_bit       <= 1'b0;
`endif
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.rx_busy    <= 1'b0;
    end else begin
      // Status outputs are single-clk strobes regardless of bclk.
      rx.rx_valid   <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;

      if (bclk) begin
        if (tick == T_LO)  samp[0] <= rxd_s;
        if (tick == T_MID) samp[1] <= rxd_s;
        tick <= (tick == T_LAST) ? '0 : tick + 1'b1;

        case (state)
          IDLE: begin
            tick <= '0;
            if (!rxd_s) begin
              state      <= START;
              rx.rx_busy <= 1'b1;
            end
          end

          START: begin
            if (tick == T_DEC && vote) begin
              // Low pulse shorter than half a bit: treat as noise.
              state      <= IDLE;
              tick       <= '0;
              rx.rx_busy <= 1'b0;
            end else if (tick == T_LAST) begin
              state <= DATA;
              bitc  <= '0;
            end
          end

          DATA: begin
            if (tick == T_DEC) shift <= {vote, shift[DATA_W-1:1]};
            if (tick == T_LAST) begin
              if (bitc == B_LAST) begin
`ifdef RS485_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bitc <= bitc + 1'b1;
              end
            end
          end

`ifdef RS485_RX_PARITY_EN
          PARITY: begin
            if (tick == T_DEC)  par_bit <= vote;
            if (tick == T_LAST) state   <= STOP;
          end
`endif

          STOP: begin
            if (tick == T_DEC) begin
              rx.rx_data   <= shift;
              rx.rx_valid  <= 1'b1;
              rx.frame_err <= ~vote;
`ifdef RS485_RX_PARITY_EN
              rx.parity_err <= (^shift) ^ par_bit;
`else
              rx.parity_err <= 1'b0;
`endif
              tick <= '0;
              // Leaving half a bit early lets the next start edge be caught without slip.
              if (vote) begin
                state      <= IDLE;
                rx.rx_busy <= 1'b0;
              end else begin
                state <= BRK;
              end
            end
          end

          BRK: begin
            tick <= '0;
            if (rxd_s) begin
              state      <= IDLE;
              rx.rx_busy <= 1'b0;
            end
          end

          default: begin
            state      <= IDLE;
            tick       <= '0;
            rx.rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
